usb_tx_sequencer: RTL and testbench

Transmit-side controller for the USB packet encoder. It accepts a packet request (token, data or handshake) and sequences the serial bit stream SYNC -> PID -> fields -> CRC -> EOP toward the downstream bit-stuffer/NRZI stage. It computes the CRC5 or CRC16 in-line and throttles on the downstream ready. It replaces the ad-hoc index counters and save strobes that previously drove the CRC and parallel-to-serial path.

---
 rtl/usb_tx_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: serialises SYNC, PID, token/data fields, CRC5/CRC16 and EOP
// toward the bit-stuffer, holding every bit while the downstream stage stalls.
module usb_tx_sequencer #(
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  pkt_kind,
    input  logic [3:0]                  pid,
    input  logic [6:0]                  addr,
    input  logic [3:0]                  endp,
    input  logic [8*MAX_DATA_BYTES-1:0] data,
    input  logic [3:0]                  data_len,
    output logic                        busy,
    output logic                        bit_out,
    output logic                        bit_valid,
    input  logic                        bit_ready,
    output logic                        sending_crc,
    output logic                        eop,
    output logic                        done,
    output logic                        err
);

    localparam int DATA_BITS = 8 * MAX_DATA_BYTES;
    localparam int CNT_W = (DATA_BITS > 16) ? $clog2(DATA_BITS) : 4;
    localparam logic [3:0] LEN_MAX = 4'(MAX_DATA_BYTES);

    localparam logic [1:0] KIND_TOKEN = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_HAND  = 2'b10;
    localparam logic [1:0] KIND_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_FIELD,
        S_CRC,
        S_EOP,
        S_DONE
    } state_t;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [15:0]            crc_q, crc_d;
    logic [1:0]             kind_q, kind_d;
    logic [3:0]             pid_q, pid_d;
    logic [6:0]             addr_q, addr_d;
    logic [3:0]             endp_q, endp_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [3:0]             len_q, len_d;

    logic                   xfer;
    logic                   field_bit;
    logic                   field_last;
    logic [CNT_W:0]         field_len;
    logic [CNT_W-1:0]       endp_idx;
    logic [3:0]             crc_top;
    logic [3:0]             crc_idx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        err_d       = 1'b0;
        kind_d      = kind_q;
        pid_d       = pid_q;
        addr_d      = addr_q;
        endp_d      = endp_q;
        data_d      = data_q;
        len_d       = len_q;
        busy        = (state_q != S_IDLE);
        bit_valid   = 1'b0;
        bit_out     = 1'b0;
        sending_crc = 1'b0;
        eop         = 1'b0;
        done        = 1'b0;
        xfer        = 1'b0;

        // Data payload is addressed by the raw bit counter: byte = cnt[..:3], bit = cnt[2:0].
        field_len  = (kind_q == KIND_TOKEN) ? (CNT_W+1)'(11) : (CNT_W+1)'({len_q, 3'b000});
        field_last = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) == field_len;
        endp_idx   = cnt_q - CNT_W'(7);
        if (kind_q == KIND_TOKEN) begin
            field_bit = (cnt_q < CNT_W'(7)) ? addr_q[cnt_q[2:0]] : endp_q[endp_idx[1:0]];
        end else begin
            field_bit = data_q[cnt_q];
        end
        crc_top = (kind_q == KIND_TOKEN) ? 4'd4 : 4'd15;
        crc_idx = crc_top - cnt_q[3:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pkt_kind == KIND_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        kind_d  = pkt_kind;
                        pid_d   = pid;
                        addr_d  = addr;
                        endp_d  = endp;
                        data_d  = data;
                        len_d   = (data_len > LEN_MAX) ? LEN_MAX : data_len;
                        crc_d   = 16'hFFFF;
                        cnt_d   = '0;
                        state_d = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                bit_valid = 1'b1;
                bit_out   = (cnt_q == CNT_W'(7));
                xfer      = bit_ready;
                if (xfer) begin
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d   = '0;
                        state_d = S_PID;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PID: begin
                bit_valid = 1'b1;
                bit_out   = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
                xfer      = bit_ready;
                if (xfer) begin
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (kind_q == KIND_HAND) begin
                            state_d = S_EOP;
                        end else if (kind_q == KIND_DATA && len_q == 4'd0) begin
                            state_d = S_CRC;
                        end else begin
                            state_d = S_FIELD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FIELD: begin
                bit_valid = 1'b1;
                bit_out   = field_bit;
                xfer      = bit_ready;
                if (xfer) begin
                    if (kind_q == KIND_TOKEN) begin
                        crc_d = {crc_q[15:5], crc5_step(crc_q[4:0], field_bit)};
                    end else begin
                        crc_d = crc16_step(crc_q, field_bit);
                    end
                    if (field_last) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CRC: begin
                // Register MSB goes out first, inverted.
                bit_valid   = 1'b1;
                sending_crc = 1'b1;
                bit_out     = ~crc_q[crc_idx];
                xfer        = bit_ready;
                if (xfer) begin
                    if (cnt_q[3:0] == crc_top) begin
                        cnt_d   = '0;
                        state_d = S_EOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_EOP: begin
                eop     = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Packet contents and CRC are re-initialised on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        crc_q  <= crc_d;
        kind_q <= kind_d;
        pid_q  <= pid_d;
        addr_q <= addr_d;
        endp_q <= endp_d;
        data_q <= data_d;
        len_q  <= len_d;
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: token, handshake, data packets, stalls,
// reserved-kind rejection and mid-packet reset.
module tb_usb_tx_sequencer;

    localparam int MAXB = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [1:0]      pkt_kind;
    logic [3:0]      pid;
    logic [6:0]      addr;
    logic [3:0]      endp;
    logic [8*MAXB-1:0] data;
    logic [3:0]      data_len;
    logic            busy;
    logic            bit_out;
    logic            bit_valid;
    logic            bit_ready;
    logic            sending_crc;
    logic            eop;
    logic            done;
    logic            err;

    usb_tx_sequencer #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_kind(pkt_kind), .pid(pid),
        .addr(addr), .endp(endp), .data(data), .data_len(data_len), .busy(busy),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sending_crc(sending_crc), .eop(eop), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Results of the last packet run
    logic [127:0] got_vec;
    int           got_n, eop_cyc, done_cyc, crc_bits, eop_n, done_n, err_n;
    logic         busy_at_done, busy_after;

    // Expected serial stream
    logic [127:0] exp_vec;
    int           exp_n;

    task automatic put(input logic b);
        exp_vec[exp_n] = b;
        exp_n++;
    endtask

    function automatic logic [15:0] ref_crc16(input logic [63:0] d, input int nbits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ 16'h8005;
            else              c = (c << 1);
        end
        return c;
    endfunction

    // crc5_field: complemented CRC5 register, emitted MSB first.
    task automatic build_exp(input logic [1:0] kind, input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] d, input int len,
                             input logic [4:0] crc5_field);
        logic [15:0] c16;
        exp_vec = '0;
        exp_n   = 0;
        for (int i = 0; i < 7; i++) put(1'b0);
        put(1'b1);
        for (int i = 0; i < 4; i++) put(p[i]);
        for (int i = 0; i < 4; i++) put(~p[i]);
        if (kind == 2'b00) begin
            for (int i = 0; i < 7; i++) put(a[i]);
            for (int i = 0; i < 4; i++) put(e[i]);
            for (int i = 4; i >= 0; i--) put(crc5_field[i]);
        end else if (kind == 2'b01) begin
            for (int i = 0; i < 8*len; i++) put(d[i]);
            c16 = ~ref_crc16(d, 8*len);
            for (int i = 15; i >= 0; i--) put(c16[i]);
        end
    endtask

    task automatic run_pkt(input logic [1:0] kind, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d, input logic [3:0] len,
                           input bit toggle, input bit poke);
        int   cyc;
        bit   fin;
        bit   held_valid;
        logic held_bit;
        got_vec = '0; got_n = 0; eop_cyc = -1; done_cyc = -1; crc_bits = 0;
        eop_n = 0; done_n = 0; err_n = 0; busy_at_done = 1'b0; busy_after = 1'b1;
        held_valid = 1'b0; held_bit = 1'b0; fin = 1'b0;
        start = 1'b1; pkt_kind = kind; pid = p; addr = a; endp = e; data = d; data_len = len;
        bit_ready = 1'b1;
        cyc = 0;
        while (!fin && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (poke && cyc == 5) begin
                start = 1'b1; pkt_kind = 2'b01; pid = 4'h3; data_len = 4'd2;
            end
            bit_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (held_valid) begin
                check("stall_hold", bit_out, held_bit);
                held_valid = 1'b0;
            end
            if (bit_valid && bit_ready) begin
                got_vec[got_n] = bit_out;
                got_n++;
                if (sending_crc) crc_bits++;
            end else if (bit_valid) begin
                held_valid = 1'b1;
                held_bit   = bit_out;
            end
            if (err) err_n++;
            if (eop) begin eop_n++; eop_cyc = cyc; end
            if (done) begin
                done_n++; done_cyc = cyc; busy_at_done = busy;
            end else if (done_n > 0) begin
                busy_after = busy;
                fin = 1'b1;
            end
        end
        if (!fin) check("pkt_timeout", 0, 1);
        bit_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pkt_kind = 2'b00; pid = 4'h0; addr = 7'h0; endp = 4'h0;
        data = '0; data_len = 4'd0; bit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outs", {busy, bit_valid, bit_out, sending_crc, eop, done, err}, 7'b0);

        // Token IN, addr 0x15 endp 0xE: final CRC5 register 5'h08, complemented 5'h17
        run_pkt(2'b00, 4'h9, 7'h15, 4'hE, 64'h0, 4'd0, 1'b0, 1'b0);
        build_exp(2'b00, 4'h9, 7'h15, 4'hE, 64'h0, 0, 5'h17);
        check("tok_nbits", got_n, 32);
        check("tok_stream", got_vec, exp_vec);
        check("tok_eop_cyc", eop_cyc, 33);
        check("tok_done_cyc", done_cyc, 34);
        check("tok_busy_done", busy_at_done, 1'b1);
        check("tok_busy_after", busy_after, 1'b0);
        check("tok_crc_bits", crc_bits, 5);
        check("tok_eop_count", eop_n, 1);

        // Handshake ACK with a stray start mid-packet
        run_pkt(2'b10, 4'h2, 7'h0, 4'h0, 64'h0, 4'd0, 1'b0, 1'b1);
        check("hs_nbits", got_n, 16);
        check("hs_stream", got_vec[15:0], 16'b1101_0010_1000_0000);
        check("hs_crc_bits", crc_bits, 0);
        check("hs_eop_cyc", eop_cyc, 17);
        check("hs_done_cyc", done_cyc, 18);
        check("hs_err", err_n, 0);

        // Zero-length data: CRC16 field is all zeros
        run_pkt(2'b01, 4'h3, 7'h0, 4'h0, 64'h0, 4'd0, 1'b0, 1'b0);
        check("d0_nbits", got_n, 32);
        check("d0_crc_field", got_vec[31:16], 16'h0000);
        check("d0_pid", got_vec[15:8], 8'b1100_0011);
        check("d0_crc_bits", crc_bits, 16);
        check("d0_eop_cyc", eop_cyc, 33);

        // Two-byte data with downstream stalling every other cycle
        run_pkt(2'b01, 4'h3, 7'h0, 4'h0, 64'hA501, 4'd2, 1'b1, 1'b0);
        build_exp(2'b01, 4'h3, 7'h0, 4'h0, 64'hA501, 2, 5'h0);
        check("d2_nbits", got_n, 48);
        check("d2_payload", got_vec[31:16], 16'hA501);
        check("d2_stream", got_vec, exp_vec);
        check("d2_crc_bits", crc_bits, 16);
        check("d2_eop_count", eop_n, 1);

        // Reserved kind is rejected
        start = 1'b1; pkt_kind = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        check("rsvd_err", err, 1'b1);
        check("rsvd_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("rsvd_err_pulse", err, 1'b0);
        check("rsvd_idle", {busy, bit_valid}, 2'b00);

        // Reset during the token FIELD state
        start = 1'b1; pkt_kind = 2'b00; pid = 4'h9; addr = 7'h15; endp = 4'hE;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("mid_field", {busy, bit_valid, sending_crc}, 3'b110);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outs", {busy, bit_valid, bit_out, sending_crc, eop, done, err}, 7'b0);
        eop_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (eop) eop_n++;
            if (done || busy) done_n++;
        end
        check("rst_no_eop", eop_n, 0);
        check("rst_stays_idle", done_n, 0);

        run_pkt(2'b00, 4'h9, 7'h15, 4'hE, 64'h0, 4'd0, 1'b0, 1'b0);
        build_exp(2'b00, 4'h9, 7'h15, 4'hE, 64'h0, 0, 5'h17);
        check("tok2_stream", got_vec, exp_vec);
        check("tok2_nbits", got_n, 32);
        check("tok2_done_cyc", done_cyc, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
